// File: rtl/fft_input_loader_if.sv
// fft_input_loader_if: valid/ready complex-sample stream feeding the FFT loader
interface fft_input_loader_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_re;
    logic [DATA_W-1:0] in_im;
    modport master (output in_valid, in_re, in_im, input in_ready);
    modport slave  (input in_valid, in_re, in_im, output in_ready);
endinterface

// File: rtl/fft_input_loader.sv
// fft_input_loader: bit-reversed 32-sample frame buffer with per-frame stage enable burst
module fft_input_loader #(
    parameter int DATA_W = 16,
    parameter int STAGES = 5
) (
    input  logic                   CLK,
    input  logic                   RST,
    fft_input_loader_if.slave      s,
    input  logic                   flush,
    output logic [32*DATA_W-1:0]   frame_re,
    output logic [32*DATA_W-1:0]   frame_im,
    output logic                   fft_en,
    output logic                   frame_loaded,
    output logic [2:0]             stage_cnt,
    output logic [4:0]             wr_idx,
    output logic [7:0]             frames_done
);
    typedef enum logic {LOAD, RUN} state_t;
    state_t              state_q, state_d;
    logic [4:0]          wr_idx_q, wr_idx_d;
    logic [2:0]          stage_cnt_q, stage_cnt_d;
    logic [7:0]          frames_done_q, frames_done_d;
    logic [32*DATA_W-1:0] buf_re_q, buf_re_d, buf_im_q, buf_im_d;
    logic [4:0]          slot;
    logic                accept;
    assign slot = {wr_idx_q[0], wr_idx_q[1], wr_idx_q[2], wr_idx_q[3], wr_idx_q[4]};
    assign s.in_ready = (state_q == LOAD) && !RST;
    assign accept = s.in_valid && s.in_ready && !flush;
    assign fft_en = state_q == RUN;
    assign frame_loaded = fft_en && stage_cnt_q == 3'd0;
    assign stage_cnt = stage_cnt_q;
    assign wr_idx = wr_idx_q;
    assign frames_done = frames_done_q;
    assign frame_re = buf_re_q;
    assign frame_im = buf_im_q;
    // Load samples at bit-reversed slots, then count out the stage enables
    always_comb begin
        state_d = state_q;
        wr_idx_d = wr_idx_q;
        stage_cnt_d = stage_cnt_q;
        frames_done_d = frames_done_q;
        buf_re_d = buf_re_q;
        buf_im_d = buf_im_q;
        if (state_q == LOAD) begin
            if (flush) begin
                wr_idx_d = '0;
            end else if (accept) begin
                buf_re_d[slot*DATA_W +: DATA_W] = s.in_re;
                buf_im_d[slot*DATA_W +: DATA_W] = s.in_im;
                wr_idx_d = wr_idx_q + 5'd1;
                if (wr_idx_q == 5'd31) state_d = RUN;
            end
        end else begin
            stage_cnt_d = stage_cnt_q + 3'd1;
            if (stage_cnt_q == 3'(STAGES - 1)) begin
                state_d = LOAD;
                stage_cnt_d = '0;
                frames_done_d = frames_done_q + 8'd1;
            end
        end
    end
    // State and buffer registers; reset empties the frame
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= LOAD;
            wr_idx_q <= '0;
            stage_cnt_q <= '0;
            frames_done_q <= '0;
            buf_re_q <= '0;
            buf_im_q <= '0;
        end else begin
            state_q <= state_d;
            wr_idx_q <= wr_idx_d;
            stage_cnt_q <= stage_cnt_d;
            frames_done_q <= frames_done_d;
            buf_re_q <= buf_re_d;
            buf_im_q <= buf_im_d;
        end
    end
endmodule

// File: tb/tb_fft_input_loader.sv
// tb_fft_input_loader: randomized scoreboard bench for the FFT input loader
module tb_fft_input_loader;
    localparam int DW = 16;
    localparam int ST = 5;
    localparam int FW = 32 * DW;
    typedef struct { logic [FW-1:0] re; logic [FW-1:0] im; } exp_t;

    logic CLK = 0;
    logic RST = 1;
    logic flush = 0;
    logic [FW-1:0] frame_re, frame_im;
    logic fft_en, frame_loaded;
    logic [2:0] stage_cnt;
    logic [4:0] wr_idx;
    logic [7:0] frames_done;

    fft_input_loader_if #(.DATA_W(DW)) bus ();

    fft_input_loader #(.DATA_W(DW), .STAGES(ST)) dut (
        .CLK(CLK), .RST(RST), .s(bus.slave), .flush(flush),
        .frame_re(frame_re), .frame_im(frame_im), .fft_en(fft_en),
        .frame_loaded(frame_loaded), .stage_cnt(stage_cnt),
        .wr_idx(wr_idx), .frames_done(frames_done)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0, n_bad = 0, n_pulse = 0, n_exp = 0;
    exp_t sb[$];
    logic [DW-1:0] m_re[32], m_im[32];
    int m_cnt = 0, m_run = 0;
    logic [7:0] m_frames = 0;

    function automatic int rev(input int i);
        int r = 0;
        for (int b = 0; b < 5; b++) if (((i >> b) & 1) != 0) r |= 1 << (4 - b);
        return r;
    endfunction

    function automatic logic [FW-1:0] pack(input logic [DW-1:0] a[32]);
        logic [FW-1:0] p;
        for (int k = 0; k < 32; k++) p[k*DW +: DW] = a[k];
        return p;
    endfunction

    task automatic chk(input string n, input logic [FW-1:0] a, input logic [FW-1:0] e);
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    // One clock cycle: drive, check against the model, then advance the model
    task automatic step(input logic r, input logic v, input logic f, input logic [DW-1:0] re, input logic [DW-1:0] im);
        RST = r; flush = f; bus.in_valid = v; bus.in_re = re; bus.in_im = im;
        @(negedge CLK);
        if (r) chk("in_ready_rst", FW'(bus.in_ready), FW'(0));
        else begin
            chk("in_ready", FW'(bus.in_ready), FW'(m_run == 0));
            chk("fft_en", FW'(fft_en), FW'(m_run != 0));
            chk("wr_idx", FW'(wr_idx), FW'(m_cnt));
            chk("stage_cnt", FW'(stage_cnt), FW'(m_run != 0 ? ST - m_run : 0));
            chk("frames_done", FW'(frames_done), FW'(m_frames));
            chk("frame_re", frame_re, pack(m_re));
            chk("frame_im", frame_im, pack(m_im));
        end
        @(posedge CLK);
        if (r) begin
            foreach (m_re[k]) begin m_re[k] = 0; m_im[k] = 0; end
            m_cnt = 0; m_run = 0; m_frames = 0; sb.delete();
        end else if (m_run != 0) begin
            m_run--;
            if (m_run == 0) m_frames++;
        end else if (f) m_cnt = 0;
        else if (v) begin
            m_re[rev(m_cnt)] = re;
            m_im[rev(m_cnt)] = im;
            m_cnt++;
            if (m_cnt == 32) begin
                m_cnt = 0;
                m_run = ST;
                sb.push_back('{pack(m_re), pack(m_im)});
                n_exp++;
            end
        end
        #1;
    endtask

    task automatic idle_until_load();
        for (int t = 0; t < 10 && m_run != 0; t++) step(0, 0, 0, 0, 0);
    endtask

    task automatic put(input logic [DW-1:0] re, input logic [DW-1:0] im, input int bubbles);
        idle_until_load();
        for (int b = 0; b < bubbles; b++) step(0, 0, 0, 0, 0);
        step(0, 1, 0, re, im);
    endtask

    // Monitor: every frame_loaded pulse must match the next scoreboarded frame
    always @(negedge CLK) begin
        if (!RST && frame_loaded) begin
            exp_t e;
            n_pulse++;
            if (sb.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL sb_empty: frame_loaded pulse with no completed frame expected");
            end else begin
                e = sb.pop_front();
                chk("sb_frame_re", frame_re, e.re);
                chk("sb_frame_im", frame_im, e.im);
                chk("sb_fft_en", FW'(fft_en), FW'(1));
            end
        end
    end

    initial begin
        foreach (m_re[k]) begin m_re[k] = 0; m_im[k] = 0; end
        bus.in_valid = 0; bus.in_re = 0; bus.in_im = 0;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // Ramp frame, back-to-back
        for (int i = 0; i < 32; i++) step(0, 1, 0, 16'(i), 16'(-i));
        chk("slot0_re", FW'(frame_re[0 +: DW]), FW'(16'd0));
        chk("slot0_im", FW'(frame_im[0 +: DW]), FW'(16'd0));
        chk("slot16_re", FW'(frame_re[16*DW +: DW]), FW'(16'd1));
        chk("slot16_im", FW'(frame_im[16*DW +: DW]), FW'(16'hFFFF));
        chk("slot24_re", FW'(frame_re[24*DW +: DW]), FW'(16'd3));
        chk("slot24_im", FW'(frame_im[24*DW +: DW]), FW'(16'hFFFD));
        chk("slot31_re", FW'(frame_re[31*DW +: DW]), FW'(16'd31));
        chk("slot31_im", FW'(frame_im[31*DW +: DW]), FW'(16'hFFE1));
        // Valid held high through RUN with changing data
        for (int i = 0; i < ST; i++) step(0, 1, 0, 16'($urandom), 16'($urandom));
        // Ten samples (first lands in slot 0), then flush alongside a valid sample
        for (int i = 0; i < 10; i++) step(0, 1, 0, 16'($urandom), 16'($urandom));
        step(0, 1, 1, 16'hBEEF, 16'hDEAD);
        chk("wr_idx_after_flush", FW'(wr_idx), FW'(0));
        for (int i = 0; i < 32; i++) put(16'($urandom), 16'($urandom), 0);
        // Valid only on every third cycle
        for (int i = 0; i < 32; i++) put(16'(i * 7), 16'(-i * 3), 2);
        // Random bubbles and occasional flushes
        for (int fr = 0; fr < 3; fr++)
            for (int i = 0; i < 32; i++) begin
                if ($urandom_range(0, 19) == 0) begin
                    idle_until_load();
                    step(0, $urandom_range(0, 1) == 1, 1, 16'($urandom), 16'($urandom));
                end
                put(16'($urandom), 16'($urandom), int'($urandom_range(0, 2)));
            end
        // Reset during the third enable cycle
        for (int i = 0; i < 32; i++) put(16'($urandom), 16'($urandom), 0);
        for (int t = 0; t < 10 && m_run != ST - 2; t++) step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        RST = 0;
        #1;
        chk("rst_fft_en", FW'(fft_en), FW'(0));
        chk("rst_stage_cnt", FW'(stage_cnt), FW'(0));
        chk("rst_wr_idx", FW'(wr_idx), FW'(0));
        chk("rst_frame_re", frame_re, FW'(0));
        chk("rst_frame_im", frame_im, FW'(0));
        chk("rst_in_ready", FW'(bus.in_ready), FW'(1));
        // 257 frames so frames_done wraps
        for (int fr = 0; fr < 257; fr++)
            for (int i = 0; i < 32; i++) put(16'($urandom), 16'($urandom), 0);
        idle_until_load();
        step(0, 0, 0, 0, 0);
        chk("frames_wrap", FW'(frames_done), FW'(8'd1));
        chk("pulse_count", FW'(n_pulse), FW'(n_exp));
        chk("sb_drained", FW'(sb.size()), FW'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
